axil_master: RTL and testbench

//  AXI4-Lite initiator bridging the core's single-outstanding load/store request port onto the AXI4-Lite
//  bus that feeds peripheral responders (uart, clint, sram). One transaction in flight; one-cycle response pulse.

---
 rtl/axil_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// -----------------------------------------------------------------------------
// axil_master
//   AXI4-Lite initiator for a core load/store port that issues one request at a
//   time. Each accepted request turns into exactly one AXI4-Lite read or write
//   transaction. The result comes back as a single-cycle resp_valid pulse.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   req_*               : core request (valid/ready, wen, addr, wdata, wstrb)
//   resp_*              : completion pulse with read data and error flag
//   ar*/r*              : AXI4-Lite read address / read data channels
//   aw*/w*/b*           : AXI4-Lite write address / write data / response
//
// Parameter
//   TIMEOUT : the maximum number of cycles spent waiting on any one handshake.
//             When this limit is reached, the transaction completes with an
//             error. A value of 0 disables the limit. The forced abort breaks
//             AXI rules and is intended only as a debug aid.
// -----------------------------------------------------------------------------
module axil_master #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    // core request / response
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // AXI4-Lite read
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    // AXI4-Lite write
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam int          CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
    localparam logic        TO_EN = (TIMEOUT != 32'd0);

    logic [2:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          ar_fire_s, r_fire_s, aw_fire_s, w_fire_s, b_fire_s;
    logic          aw_next_s, w_next_s, to_hit_s;
    logic [CW-1:0] cnt_inc_s;

    // Every AXI control output is decoded from registered state only, so a
    // valid never depends on a ready in the same cycle.
    assign req_ready  = (state_q == S_IDLE);
    assign arvalid    = (state_q == S_AR);
    assign rready     = (state_q == S_R);
    assign awvalid    = (state_q == S_WR) && !aw_done_q;
    assign wvalid     = (state_q == S_WR) && !w_done_q;
    assign bready     = (state_q == S_B);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;

    assign ar_fire_s = arvalid && arready;
    assign r_fire_s  = rready && rvalid;
    assign aw_fire_s = awvalid && awready;
    assign w_fire_s  = wvalid && wready;
    assign b_fire_s  = bready && bvalid;
    assign aw_next_s = aw_done_q | aw_fire_s;
    assign w_next_s  = w_done_q | w_fire_s;
    assign cnt_inc_s = cnt_q + CW'(1);
    // The limit is reached on the edge that would push the wait count to
    // TIMEOUT. A handshake on that same edge still takes priority.
    assign to_hit_s  = TO_EN && (cnt_inc_s == TO_C);

    // Next-state, payload latch and timeout counter logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d     = {CW{1'b0}};
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = req_wen ? S_WR : S_AR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                if (ar_fire_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_R;
                end else if (to_hit_s) begin
                    cnt_d   = {CW{1'b0}};
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_R: begin
                if (r_fire_s) begin
                    cnt_d   = {CW{1'b0}};
                    rdata_d = rdata;
                    // SLVERR (2'b10) and DECERR (2'b11) both report an error
                    err_d   = (rresp >= 2'b10);
                    state_d = S_RESP;
                end else if (to_hit_s) begin
                    cnt_d   = {CW{1'b0}};
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_WR: begin
                // Address and data channels retire independently. Both may fire
                // in the same cycle.
                if (aw_fire_s || w_fire_s) begin
                    cnt_d     = {CW{1'b0}};
                    aw_done_d = aw_next_s;
                    w_done_d  = w_next_s;
                    if (aw_next_s && w_next_s) begin
                        state_d = S_B;
                    end else begin
                        state_d = S_WR;
                    end
                end else if (to_hit_s) begin
                    cnt_d     = {CW{1'b0}};
                    aw_done_d = 1'b1;
                    w_done_d  = 1'b1;
                    rdata_d   = 32'd0;
                    err_d     = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_B: begin
                if (b_fire_s) begin
                    cnt_d   = {CW{1'b0}};
                    rdata_d = 32'd0;
                    err_d   = (bresp >= 2'b10);
                    state_d = S_RESP;
                end else if (to_hit_s) begin
                    cnt_d   = {CW{1'b0}};
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_RESP: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// -----------------------------------------------------------------------------
// tb_axil_master
//   Self-checking bench for axil_master, built with TIMEOUT=8. A per-cycle
//   responder applies a requested number of wait cycles to each handshake.
//   The expected completion cycle, read data, error flag and per-channel valid
//   durations come from the handshake timing rules, using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_axil_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction. For a read, da and dr are the AR and R wait
    // cycles. For a write, da, dw and dr are the AW, W and B wait cycles.
    // A wait of TO or more cycles means the responder never becomes ready.
    task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int da, input int dw, input int dr,
                           input logic [1:0] resp, input logic [31:0] rdat);
        int exp_cyc, exp_a, exp_w, m;
        int a_cnt, w_cnt, r_cnt, b_cnt, guard;
        logic exp_err, aw_f, w_f, done;
        logic [31:0] exp_rd;
        // reference expectations
        exp_w = dw + 1;
        if (!wen) begin
            if (da >= TO) begin
                exp_cyc = TO + 1; exp_err = 1'b1; exp_rd = 32'd0; exp_a = TO;
            end else if (dr >= TO) begin
                exp_cyc = da + TO + 2; exp_err = 1'b1; exp_rd = 32'd0; exp_a = da + 1;
            end else begin
                exp_cyc = da + dr + 3; exp_err = resp[1]; exp_rd = rdat; exp_a = da + 1;
            end
        end else begin
            m = (da > dw) ? da : dw;
            exp_a  = da + 1;
            exp_rd = 32'd0;
            if (dr >= TO) begin
                exp_cyc = m + TO + 2; exp_err = 1'b1;
            end else begin
                exp_cyc = m + dr + 3; exp_err = resp[1];
            end
        end
        // issue the request once the bridge is idle
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        a_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        aw_f = 1'b0; w_f = 1'b0; done = 1'b0;
        for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
            @(negedge clk);
            if (req_ready) chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            // read address channel
            if (arvalid) begin
                a_cnt++;
                if (araddr !== addr) chk("araddr", araddr, addr);
                arready = (a_cnt > da) && (da < TO);
            end else begin
                arready = 1'($urandom);
            end
            // read data channel; stray rvalid outside R carries junk
            if (rready) begin
                if (a_cnt != exp_a) chk("rready_early", a_cnt, exp_a);
                r_cnt++;
                rvalid = (r_cnt > dr) && (dr < TO);
                rdata  = rdat;
                rresp  = resp;
            end else begin
                rvalid = 1'($urandom);
                rdata  = $urandom;
                rresp  = 2'($urandom);
            end
            // write address / data channels
            if (awvalid) begin
                w_cnt = w_cnt;
                if (awaddr !== addr) chk("awaddr", awaddr, addr);
                a_cnt++;
                awready = (a_cnt > da);
                if (awready) aw_f = 1'b1;
            end else begin
                awready = 1'($urandom);
            end
            if (wvalid) begin
                w_cnt++;
                if (wdata !== wd) chk("wdata", wdata, wd);
                if (wstrb !== ws) chk("wstrb", {28'd0, wstrb}, {28'd0, ws});
                wready = (w_cnt > dw);
                if (wready) w_f = 1'b1;
            end else begin
                wready = 1'($urandom);
            end
            // write response channel; bready only after both AW and W fired
            if (bready) begin
                if (b_cnt == 0) chk("b_after_aw_w", {30'd0, aw_f, w_f}, 32'd3);
                b_cnt++;
                bvalid = (b_cnt > dr) && (dr < TO);
                bresp  = resp;
            end else begin
                bvalid = 1'($urandom);
                bresp  = 2'($urandom);
            end
            if (resp_valid) begin
                done = 1'b1;
                chk("resp_cycle", cyc, exp_cyc);
                chk("resp_rdata", resp_rdata, exp_rd);
                chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
                if (!wen) begin
                    chk("arvalid_cycles", a_cnt, exp_a);
                end else begin
                    chk("awvalid_cycles", a_cnt, exp_a);
                    chk("wvalid_cycles", w_cnt, exp_w);
                end
                @(negedge clk);
                chk("resp_one_cycle", {30'd0, resp_valid, req_ready}, 32'd1);
            end
        end
        if (!done) chk("resp_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int da, dw, dr;
        logic [1:0] rs;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {25'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 32'd0);
        chk("rst_addr", araddr | awaddr | wdata | {28'd0, wstrb}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_txn(1'b0, 32'h8000_0000, 32'd0, 4'd0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, 2, 0, 0, 2'b00, 32'd0);
        run_txn(1'b1, 32'h0200_4000, 32'h1234_5678, 4'b1111, 0, 0, 0, 2'b10, 32'd0);
        run_txn(1'b1, 32'h0200_4004, 32'hCAFE_F00D, 4'b1100, 0, 3, 1, 2'b11, 32'd0);
        run_txn(1'b0, 32'h8000_0010, 32'd0, 4'd0, 100, 0, 0, 2'b00, 32'h1111_2222);
        // two reads back to back: the next one starts as soon as req_ready returns
        run_txn(1'b0, 32'h8000_0020, 32'd0, 4'd0, 0, 0, 0, 2'b00, 32'h0BAD_F00D);
        run_txn(1'b0, 32'h8000_0024, 32'd0, 4'd0, 0, 0, 0, 2'b10, 32'h5555_AAAA);
        run_txn(1'b0, 32'h8000_0028, 32'd0, 4'd0, 1, 0, 100, 2'b00, 32'h7777_7777);
        run_txn(1'b1, 32'h8000_002C, 32'h9999_9999, 4'b0110, 1, 2, 100, 2'b00, 32'd0);

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            da = int'($urandom_range(0, 4));
            dw = int'($urandom_range(0, 4));
            dr = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 4));
            rs = 2'($urandom);
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), da, dw, dr, rs, $urandom);
        end

        // reset in the middle of a write, with a stray bvalid present
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h1000_0000; req_wdata = 32'h0000_00AA;
        req_wstrb = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
        rst = 1'b1;
        bvalid = 1'b1;
        bresp = 2'b10;
        @(negedge clk);
        chk("mid_rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {30'd0, resp_valid, bready}, 32'd0);
        end
        bvalid = 1'b0;
        run_txn(1'b0, 32'h8000_0100, 32'd0, 4'd0, 0, 0, 1, 2'b00, 32'hFEED_FACE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
